cut_response_compactor: RTL and testbench
=========================================

Name: cut_response_compactor

Overview:
- Downstream consumer of a combinational benchmark circuit (5-in / 17-out class) in the AIG dataset flow.
- Captures one response vector per accepted pattern through a valid/ready handshake.
- Compacts the responses into a 17-bit MISR signature over a programmed pattern count.
- Compares the final signature against a golden value, so that balanced and unbalanced netlists of the same benchmark can be checked for equivalence in simulation or on FPGA.

Parameters:
- OUT_W, 17, width of the response vector and of the signature.
- CNT_W, 6, width of the pattern counter; supports up to 2^CNT_W - 1 patterns.
- MISR_POLY, 17'h04001, low-order feedback taps (x^17 + x^14 + 1) XORed in when the MSB shifts out.
- MISR_SEED, 17'h00000, signature value loaded on start.

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle pulse; begins a run. Sampled only in IDLE or DONE.
- num_patterns, in, CNT_W, patterns per run; sampled on start. 0 is treated as 1.
- golden_sig, in, OUT_W, expected signature; sampled on start.
- resp_valid, in, 1, upstream presents a response vector.
- resp_ready, out, 1, compactor accepts a response.
- resp_data, in, OUT_W, benchmark outputs {f17..f1}; f1 is bit 0.
- busy, out, 1, high in RUN.
- sig_valid, out, 1, high in DONE.
- signature, out, OUT_W, current MISR value; live during RUN, frozen in DONE.
- pass, out, 1, signature == golden; valid only while sig_valid = 1, otherwise 0.
- accepted, out, CNT_W, responses accepted in the current run.

Behaviour:
- Reset (asynchronous, rst = 1), all outputs and state cleared:
  - state = IDLE; signature = MISR_SEED; accepted = 0.
  - resp_ready = 0, busy = 0, sig_valid = 0, pass = 0.
  - Latched golden value and latched pattern target = 0.
- State IDLE:
  - resp_ready = 0.
  - On start: load signature = MISR_SEED, accepted = 0, latch golden_sig and max(num_patterns, 1). Go to RUN next cycle.
- State RUN:
  - resp_ready = 1 combinationally (no dependence on resp_valid).
  - A transfer occurs when resp_valid & resp_ready on a rising edge.
  - On each transfer, same edge:
    - signature <= (signature << 1, truncated to OUT_W) ^ (signature[OUT_W-1] ? MISR_POLY : 0) ^ resp_data.
    - accepted <= accepted + 1.
  - When accepted + 1 == target on a transfer, go to DONE next cycle.
  - Latency: the final signature is visible with sig_valid one cycle after the last transfer edge.
  - start during RUN is ignored.
  - resp_valid low for any number of cycles stalls the run; no timeout.
- State DONE:
  - resp_ready = 0; signature and accepted hold.
  - sig_valid = 1; pass = (signature == latched golden).
  - start re-arms as in IDLE: sig_valid drops the next cycle and signature returns to the seed.
- start and resp_valid in the same cycle in IDLE or DONE: no transfer; the run begins on the next cycle.
- resp_data is not interpreted beyond the XOR; X on resp_data while no transfer occurs has no effect.
- Counter never wraps: target ≤ 2^CNT_W - 1 and the run ends at target.
- rst asserted mid-RUN aborts the run immediately with reset values; no partial signature is retained.

Decomposition:
- Shared package cut_test_pkg holds:
  - localparam OUT_W = 17.
  - MISR_POLY_17 = 17'h04001.
  - typedef enum {IDLE, RUN, DONE} cmp_state_t.
  - typedef logic [16:0] resp_vec_t.
- One sub-module: misr_step, a purely combinational next-signature function (sig, data) -> next_sig. It is reused by the upstream pattern-generator block and by the bench reference model.
- The FSM and counter stay in cut_response_compactor.

Test Plan:
- Single pattern: start with num_patterns = 1 and golden = 17'h00001, transfer resp_data = 17'h00001 → sig_valid = 1 one cycle later, signature = 17'h00001, pass = 1, accepted = 1.
- MSB feedback: num_patterns = 2, transfers 17'h1FFFF then 17'h00000 → signature = 17'h1BFFF. golden = 17'h1BFFF gives pass = 1; golden = 17'h1BFFE gives pass = 0.
- Handshake stalls: num_patterns = 3 with resp_valid toggled 1,0,0,1,0,1 → exactly 3 transfers, resp_ready = 0 in IDLE and DONE, and the result equals the unstalled result.
- Start in DONE and num_patterns = 0: after a completed run, start with num_patterns = 0 → run of 1 pattern. Signature returns to seed first, and sig_valid drops for at least one cycle.
- Exhaustive run: num_patterns = 32, 32 responses from the benchmark driven by a counter → signature equals the misr_step model. pass matches for the balanced netlist and fails for a netlist with one injected output fault.
- Reset mid-run: assert rst after 5 of 10 transfers → all outputs are at reset values immediately (asynchronously). A subsequent start and 10 transfers give the same signature as a clean run.

Source files
------------

// File: rtl/cut_test_pkg.sv
// cut_test_pkg: shared types and constants for the benchmark response compaction slice.
package cut_test_pkg;
   localparam int OUT_W = 17;
   localparam logic [16:0] MISR_POLY_17 = 17'h04001;
   typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t;
   typedef logic [16:0] resp_vec_t;
endpackage

// File: rtl/misr_step.sv
// misr_step: one combinational MISR update, shift left with feedback on MSB, then fold in data.
module misr_step import cut_test_pkg::*; #(
   parameter int W = OUT_W,
   parameter logic [W-1:0] POLY = MISR_POLY_17
) (
   input  logic [W-1:0] sig,
   input  logic [W-1:0] data,
   output logic [W-1:0] next_sig
);
   assign next_sig = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ data;
endmodule

// File: rtl/cut_response_compactor.sv
// cut_response_compactor: accepts benchmark responses over valid/ready, compacts them into
// a MISR signature over a programmed pattern count and flags a match against a golden value.
module cut_response_compactor import cut_test_pkg::*; #(
   parameter int OUT_W = cut_test_pkg::OUT_W,
   parameter int CNT_W = 6,
   parameter logic [OUT_W-1:0] MISR_POLY = MISR_POLY_17,
   parameter logic [OUT_W-1:0] MISR_SEED = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_patterns,
   input  logic [OUT_W-1:0] golden_sig,
   input  logic             resp_valid,
   output logic             resp_ready,
   input  logic [OUT_W-1:0] resp_data,
   output logic             busy,
   output logic             sig_valid,
   output logic [OUT_W-1:0] signature,
   output logic             pass,
   output logic [CNT_W-1:0] accepted
);
   cmp_state_t state_q, state_d;
   logic [OUT_W-1:0] sig_q, golden_q, sig_next;
   logic [CNT_W-1:0] acc_q, target_q;
   logic arm, xfer;

   // start is honoured from IDLE and DONE alike; a start cycle never transfers
   assign arm  = start && state_q != RUN;
   assign xfer = resp_valid && state_q == RUN;

   misr_step #(.W(OUT_W), .POLY(MISR_POLY)) u_misr (
      .sig(sig_q),
      .data(resp_data),
      .next_sig(sig_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = arm ? RUN : (xfer && acc_q + 1'b1 == target_q) ? DONE : state_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q    <= MISR_SEED;
         acc_q    <= '0;
         golden_q <= '0;
         target_q <= '0;
      end else if (arm) begin
         sig_q    <= MISR_SEED;
         acc_q    <= '0;
         golden_q <= golden_sig;
         target_q <= (num_patterns == '0) ? CNT_W'(1) : num_patterns;
      end else if (xfer) begin
         sig_q <= sig_next;
         acc_q <= acc_q + 1'b1;
      end
   end

   always_comb begin
      resp_ready = state_q == RUN;
      busy       = state_q == RUN;
      sig_valid  = state_q == DONE;
      pass       = state_q == DONE && sig_q == golden_q;
      signature  = sig_q;
      accepted   = acc_q;
   end
endmodule

// File: tb/tb_cut_response_compactor.sv
// tb_cut_response_compactor: directed scenario tests with hand-computed signatures
// and an independent MISR reference for the longer runs.
module tb_cut_response_compactor;
   logic        clk = 0;
   logic        rst = 1;
   logic        start = 0;
   logic [5:0]  num_patterns = 0;
   logic [16:0] golden_sig = 0;
   logic        resp_valid = 0;
   logic        resp_ready;
   logic [16:0] resp_data = 0;
   logic        busy, sig_valid, pass;
   logic [16:0] signature;
   logic [5:0]  accepted;
   int n_tests = 0;
   int n_fail = 0;

   cut_response_compactor dut (
      .clk(clk), .rst(rst), .start(start), .num_patterns(num_patterns),
      .golden_sig(golden_sig), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .busy(busy), .sig_valid(sig_valid),
      .signature(signature), .pass(pass), .accepted(accepted)
   );

   always #5 clk = ~clk;

   function automatic logic [16:0] misr_ref(input logic [16:0] s, input logic [16:0] d);
      logic [16:0] t;
      t = {s[15:0], 1'b0};
      if (s[16]) begin
         t[14] = ~t[14];
         t[0]  = ~t[0];
      end
      return t ^ d;
   endfunction

   // stand-in for the 5-in / 17-out benchmark netlist
   function automatic logic [16:0] bench_fn(input logic [4:0] x);
      return {x, x ^ 5'h15, x & {x[0], x[4:1]}, x[4] | x[0], x[3] ^ x[1]};
   endfunction

   task automatic start_run(input logic [5:0] n, input logic [16:0] g);
      @(posedge clk); #1;
      start = 1; num_patterns = n; golden_sig = g;
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic xfer(input logic [16:0] d);
      resp_valid = 1; resp_data = d;
      @(posedge clk); #1;
      resp_valid = 0; resp_data = 'x;
   endtask

   task automatic test_reset;
      #3;
      n_tests++; if (signature !== 17'h0) begin n_fail++; $display("FAIL reset_sig got %h want 00000", signature); end
      n_tests++; if (accepted !== 6'd0) begin n_fail++; $display("FAIL reset_acc got %0d want 0", accepted); end
      n_tests++; if ({resp_ready, busy, sig_valid, pass} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {resp_ready, busy, sig_valid, pass}); end
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;
      n_tests++; if (resp_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready got %b want 0", resp_ready); end
   endtask

   task automatic test_single;
      start_run(6'd1, 17'h00001);
      n_tests++; if ({busy, resp_ready, sig_valid} !== 3'b110) begin n_fail++; $display("FAIL single_run_flags got %b want 110", {busy, resp_ready, sig_valid}); end
      xfer(17'h00001);
      n_tests++; if (sig_valid !== 1'b1) begin n_fail++; $display("FAIL single_sig_valid got %b want 1", sig_valid); end
      n_tests++; if (signature !== 17'h00001) begin n_fail++; $display("FAIL single_sig got %h want 00001", signature); end
      n_tests++; if (pass !== 1'b1) begin n_fail++; $display("FAIL single_pass got %b want 1", pass); end
      n_tests++; if (accepted !== 6'd1) begin n_fail++; $display("FAIL single_acc got %0d want 1", accepted); end
      n_tests++; if ({resp_ready, busy} !== 2'b00) begin n_fail++; $display("FAIL done_ready got %b want 00", {resp_ready, busy}); end
      resp_valid = 1; resp_data = 17'h0FFFF;
      @(posedge clk); #1;
      resp_valid = 0;
      n_tests++; if ({signature, accepted} !== {17'h00001, 6'd1}) begin n_fail++; $display("FAIL done_hold got %h/%0d want 00001/1", signature, accepted); end
   endtask

   task automatic test_msb_feedback;
      start_run(6'd2, 17'h1BFFF);
      xfer(17'h1FFFF);
      n_tests++; if ({sig_valid, signature} !== {1'b0, 17'h1FFFF}) begin n_fail++; $display("FAIL fb_mid got %b/%h want 0/1ffff", sig_valid, signature); end
      xfer(17'h00000);
      n_tests++; if (signature !== 17'h1BFFF) begin n_fail++; $display("FAIL fb_sig got %h want 1bfff", signature); end
      n_tests++; if (pass !== 1'b1) begin n_fail++; $display("FAIL fb_pass got %b want 1", pass); end
      start_run(6'd2, 17'h1BFFE);
      xfer(17'h1FFFF);
      xfer(17'h00000);
      n_tests++; if ({sig_valid, pass} !== 2'b10) begin n_fail++; $display("FAIL fb_badgold got %b want 10", {sig_valid, pass}); end
   endtask

   task automatic test_stall;
      logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [16:0] dat [3] = '{17'h10000, 17'h00003, 17'h0000F};
      int j = 0;
      int seen = 0;
      start_run(6'd3, 17'h0800B);
      for (int k = 0; k < 6; k++) begin
         resp_valid = pat[k];
         resp_data = pat[k] ? dat[j] : 'x;
         if (pat[k]) j++;
         #1;
         if (resp_valid && resp_ready) seen++;
         @(posedge clk); #1;
      end
      resp_valid = 0;
      n_tests++; if (seen !== 3) begin n_fail++; $display("FAIL stall_xfers got %0d want 3", seen); end
      n_tests++; if (accepted !== 6'd3) begin n_fail++; $display("FAIL stall_acc got %0d want 3", accepted); end
      n_tests++; if (signature !== 17'h0800B) begin n_fail++; $display("FAIL stall_sig got %h want 0800b", signature); end
      n_tests++; if ({sig_valid, pass, resp_ready} !== 3'b110) begin n_fail++; $display("FAIL stall_flags got %b want 110", {sig_valid, pass, resp_ready}); end
      start_run(6'd3, 17'h0800B);
      for (int k = 0; k < 3; k++) xfer(dat[k]);
      n_tests++; if (signature !== 17'h0800B) begin n_fail++; $display("FAIL nostall_sig got %h want 0800b", signature); end
   endtask

   task automatic test_restart_zero;
      @(posedge clk); #1;
      start = 1; num_patterns = 6'd0; golden_sig = 17'h00005;
      resp_valid = 1; resp_data = 17'h1FFFF;
      @(posedge clk); #1;
      start = 0; resp_valid = 0; resp_data = 'x;
      n_tests++; if ({sig_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL rearm_flags got %b want 01", {sig_valid, busy}); end
      n_tests++; if ({signature, accepted} !== {17'h0, 6'd0}) begin n_fail++; $display("FAIL rearm_seed got %h/%0d want 00000/0", signature, accepted); end
      xfer(17'h00005);
      n_tests++; if ({sig_valid, pass, accepted} !== {2'b11, 6'd1}) begin n_fail++; $display("FAIL zero_count got %b/%b/%0d want 1/1/1", sig_valid, pass, accepted); end
      n_tests++; if (signature !== 17'h00005) begin n_fail++; $display("FAIL zero_sig got %h want 00005", signature); end
   endtask

   task automatic test_exhaustive;
      logic [16:0] good = '0;
      logic [16:0] bad = '0;
      logic [16:0] d;
      for (int i = 0; i < 32; i++) begin
         d = bench_fn(5'(i));
         good = misr_ref(good, d);
         bad = misr_ref(bad, (i == 13) ? d ^ 17'h00080 : d);
      end
      start_run(6'd32, good);
      for (int i = 0; i < 32; i++) xfer(bench_fn(5'(i)));
      n_tests++; if (signature !== good) begin n_fail++; $display("FAIL exh_sig got %h want %h", signature, good); end
      n_tests++; if ({sig_valid, pass, accepted} !== {2'b11, 6'd32}) begin n_fail++; $display("FAIL exh_pass got %b/%b/%0d want 1/1/32", sig_valid, pass, accepted); end
      start_run(6'd32, good);
      for (int i = 0; i < 32; i++) xfer((i == 13) ? bench_fn(5'(i)) ^ 17'h00080 : bench_fn(5'(i)));
      n_tests++; if (signature !== bad) begin n_fail++; $display("FAIL fault_sig got %h want %h", signature, bad); end
      n_tests++; if ({sig_valid, pass} !== 2'b10) begin n_fail++; $display("FAIL fault_pass got %b want 10", {sig_valid, pass}); end
   endtask

   task automatic test_reset_mid_run;
      logic [16:0] ref_sig = '0;
      for (int i = 0; i < 10; i++) ref_sig = misr_ref(ref_sig, bench_fn(5'(i + 7)));
      start_run(6'd10, ref_sig);
      for (int i = 0; i < 5; i++) xfer(bench_fn(5'(i + 7)));
      #2 rst = 1;
      #1;
      n_tests++; if ({signature, accepted} !== {17'h0, 6'd0}) begin n_fail++; $display("FAIL midrst_state got %h/%0d want 00000/0", signature, accepted); end
      n_tests++; if ({resp_ready, busy, sig_valid, pass} !== 4'b0000) begin n_fail++; $display("FAIL midrst_flags got %b want 0000", {resp_ready, busy, sig_valid, pass}); end
      @(posedge clk); #1;
      rst = 0;
      start_run(6'd10, ref_sig);
      for (int i = 0; i < 10; i++) xfer(bench_fn(5'(i + 7)));
      n_tests++; if (signature !== ref_sig) begin n_fail++; $display("FAIL rerun_sig got %h want %h", signature, ref_sig); end
      n_tests++; if ({sig_valid, pass, accepted} !== {2'b11, 6'd10}) begin n_fail++; $display("FAIL rerun_flags got %b/%b/%0d want 1/1/10", sig_valid, pass, accepted); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_msb_feedback;
      test_stall;
      test_restart_zero;
      test_exhaustive;
      test_reset_mid_run;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
